// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions: load-type codes, write-back source codes and
// datapath width. The MEM/WB stage and the write-back mux both import these.
package cpu_defs;

    localparam int XLEN = 32;

    // Load type presented with a load instruction.
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // Write-back data source select.
    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC  = 2'b10;
    localparam logic [1:0] WDSEL_IMM = 2'b11;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle between the MEM stage (master) and the MEM/WB register (slave).
//
// Flow semantics: in_valid marks a real instruction on the in_* fields in the
// current cycle; it is taken on the next rising edge unless stall or flush is
// high. There is no ready: the upstream pipeline control owns stall/flush and
// the stage never back-pressures. valid marks a real instruction in WB.
interface mem_wb_stage_if #(
    parameter int XLEN  = cpu_defs::XLEN,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    // pipeline control
    logic              stall;
    logic              flush;
    // MEM-stage side
    logic              in_valid;
    logic [XLEN-1:0]   in_aluout;
    logic [XLEN-1:0]   in_memword;
    logic [2:0]        in_DMType;
    logic              in_MemRead;
    logic [XLEN-1:0]   in_immout;
    logic [XLEN-1:0]   in_pcplus4;
    logic [1:0]        in_WDSel;
    logic [RA_W-1:0]   in_rd;
    logic              in_RegWrite;
    // WB side
    logic              valid;
    logic [XLEN-1:0]   dout;
    logic [XLEN-1:0]   aluout;
    logic [XLEN-1:0]   immout;
    logic [XLEN-1:0]   resetAddr;
    logic [1:0]        WDSel;
    logic [RA_W-1:0]   rd;
    logic              RegWrite;
    logic              misalign_err;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output stall, flush, in_valid, in_aluout, in_memword, in_DMType,
               in_MemRead, in_immout, in_pcplus4, in_WDSel, in_rd, in_RegWrite,
        input  valid, dout, aluout, immout, resetAddr, WDSel, rd, RegWrite,
               misalign_err, retire_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_aluout, in_memword, in_DMType,
               in_MemRead, in_immout, in_pcplus4, in_WDSel, in_rd, in_RegWrite,
        output valid, dout, aluout, immout, resetAddr, WDSel, rd, RegWrite,
               misalign_err, retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Combinational load aligner: picks the addressed byte/half from a raw
// little-endian memory word and extends it. Also reports whether the offset
// is illegal for the access size (undefined types behave like lw).
module load_extract
    import cpu_defs::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      DMType,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Lane select, then extension by load type.
    always_comb begin
        half_v     = off[1] ? word[31:16] : word[15:0];
        byte_v     = word[7:0];
        data       = word;
        misaligned = 1'b0;
        case (off)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (DMType)
            DM_HALF: begin
                data       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = off[0];
            end
            DM_HALF_U: begin
                data       = {{(XLEN-16){1'b0}}, half_v};
                misaligned = off[0];
            end
            DM_BYTE:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            DM_BYTE_U: data = {{(XLEN-8){1'b0}}, byte_v};
            default: begin
                data       = word;
                misaligned = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Aligns load data before the register, gates the
// register-file write (x0, bubbles, misaligned loads), flags misaligned loads
// for one cycle and counts retired instructions.
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter int XLEN  = cpu_defs::XLEN,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    logic [XLEN-1:0] ext_data;
    logic            ext_misaligned;
    logic            misaligned;
    logic            wr_en;

    load_extract u_load_extract (
        .word       (bus.in_memword),
        .off        (bus.in_aluout[1:0]),
        .DMType     (bus.in_DMType),
        .data       (ext_data),
        .misaligned (ext_misaligned)
    );

    // Misalignment only matters for a real load; a faulting load never writes.
    always_comb begin
        misaligned = bus.in_valid & bus.in_MemRead & ext_misaligned;
        wr_en      = bus.in_valid & bus.in_RegWrite &
                     (bus.in_rd != RA_W'(0)) & ~misaligned;
    end

    // Stage register: rst > flush > stall > capture. Flush keeps the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid        <= 1'b0;
            bus.dout         <= '0;
            bus.aluout       <= '0;
            bus.immout       <= '0;
            bus.resetAddr    <= '0;
            bus.WDSel        <= WDSEL_ALU;
            bus.rd           <= '0;
            bus.RegWrite     <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.retire_cnt   <= '0;
        end else if (bus.flush) begin
            bus.valid        <= 1'b0;
            bus.dout         <= '0;
            bus.aluout       <= '0;
            bus.immout       <= '0;
            bus.resetAddr    <= '0;
            bus.WDSel        <= WDSEL_ALU;
            bus.rd           <= '0;
            bus.RegWrite     <= 1'b0;
            bus.misalign_err <= 1'b0;
        end else if (bus.stall) begin
            // hold everything; the error flag is a single-cycle pulse
            bus.misalign_err <= 1'b0;
        end else begin
            bus.valid        <= bus.in_valid;
            bus.dout         <= bus.in_MemRead ? ext_data : '0;
            bus.aluout       <= bus.in_aluout;
            bus.immout       <= bus.in_immout;
            bus.resetAddr    <= bus.in_pcplus4;
            bus.WDSel        <= bus.in_WDSel;
            bus.rd           <= bus.in_rd;
            bus.RegWrite     <= wr_en;
            bus.misalign_err <= misaligned;
            if (bus.in_valid) begin
                bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. A reference model computes the expected
// stage contents for every clock step; results are queued when driven and
// popped when the DUT output is sampled. A second instance with a 4-bit
// retire counter shares the same stimulus so counter wrap is reachable.
module tb_mem_wb_stage;
    import cpu_defs::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] dout;
        logic [31:0] aluout;
        logic [31:0] immout;
        logic [31:0] resetaddr;
        logic [1:0]  wdsel;
        logic [4:0]  rd;
        logic        regwrite;
        logic        misalign_err;
        logic [31:0] cnt;
        logic [3:0]  cnt_n;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    exp_t  exp_q[$];
    exp_t  m = '0;
    int    n_checks = 0;
    int    n_fail = 0;

    mem_wb_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(32)) bus ();
    mem_wb_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  bus_n ();

    mem_wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    mem_wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(4))  dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    assign bus_n.stall       = bus.stall;
    assign bus_n.flush       = bus.flush;
    assign bus_n.in_valid    = bus.in_valid;
    assign bus_n.in_aluout   = bus.in_aluout;
    assign bus_n.in_memword  = bus.in_memword;
    assign bus_n.in_DMType   = bus.in_DMType;
    assign bus_n.in_MemRead  = bus.in_MemRead;
    assign bus_n.in_immout   = bus.in_immout;
    assign bus_n.in_pcplus4  = bus.in_pcplus4;
    assign bus_n.in_WDSel    = bus.in_WDSel;
    assign bus_n.in_rd       = bus.in_rd;
    assign bus_n.in_RegWrite = bus.in_RegWrite;

    // clock / reset
    always #5 clk = ~clk;

    // reference load extraction
    function automatic logic [31:0] ext_model(logic [31:0] w, logic [1:0] off, logic [2:0] t);
        logic [31:0] hs;
        logic [31:0] bs;
        hs = w >> (16 * int'(off[1]));
        bs = w >> (8 * int'(off));
        case (t)
            3'd1:    return {{16{hs[15]}}, hs[15:0]};
            3'd2:    return {16'h0, hs[15:0]};
            3'd3:    return {{24{bs[7]}}, bs[7:0]};
            3'd4:    return {24'h0, bs[7:0]};
            default: return w;
        endcase
    endfunction

    // reference next-state for one clock edge
    function automatic exp_t model_next(exp_t cur);
        exp_t n;
        logic mis;
        logic lw_like;
        n = cur;
        lw_like = !(bus.in_DMType inside {3'd1, 3'd2, 3'd3, 3'd4});
        mis = bus.in_valid && bus.in_MemRead &&
              ((lw_like && bus.in_aluout[1:0] != 2'b00) ||
               ((bus.in_DMType == 3'd1 || bus.in_DMType == 3'd2) && bus.in_aluout[0]));
        if (rst) begin
            n = '0;
        end else if (bus.flush) begin
            n = '0;
            n.cnt   = cur.cnt;
            n.cnt_n = cur.cnt_n;
        end else if (bus.stall) begin
            n.misalign_err = 1'b0;
        end else begin
            n.valid        = bus.in_valid;
            n.dout         = bus.in_MemRead ? ext_model(bus.in_memword, bus.in_aluout[1:0], bus.in_DMType) : 32'h0;
            n.aluout       = bus.in_aluout;
            n.immout       = bus.in_immout;
            n.resetaddr    = bus.in_pcplus4;
            n.wdsel        = bus.in_WDSel;
            n.rd           = bus.in_rd;
            n.regwrite     = bus.in_valid && bus.in_RegWrite && bus.in_rd != 5'd0 && !mis;
            n.misalign_err = mis;
            if (bus.in_valid) begin
                n.cnt   = cur.cnt + 32'd1;
                n.cnt_n = cur.cnt_n + 4'd1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: one instruction on the MEM side
    task automatic drive(input logic v, input logic mr, input logic [2:0] dmt,
                         input logic [31:0] alu, input logic [31:0] word,
                         input logic [4:0] rdv, input logic rw, input logic [1:0] wds);
        bus.in_valid    = v;
        bus.in_MemRead  = mr;
        bus.in_DMType   = dmt;
        bus.in_aluout   = alu;
        bus.in_memword  = word;
        bus.in_rd       = rdv;
        bus.in_RegWrite = rw;
        bus.in_WDSel    = wds;
        bus.in_immout   = $urandom;
        bus.in_pcplus4  = $urandom;
    endtask

    // one clock edge: queue the expectation, then compare the popped entry
    task automatic step(input string tag);
        exp_t e;
        m = model_next(m);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/valid"},     32'(bus.valid),        32'(e.valid));
        chk({tag, "/dout"},      bus.dout,              e.dout);
        chk({tag, "/aluout"},    bus.aluout,            e.aluout);
        chk({tag, "/immout"},    bus.immout,            e.immout);
        chk({tag, "/resetAddr"}, bus.resetAddr,         e.resetaddr);
        chk({tag, "/WDSel"},     32'(bus.WDSel),        32'(e.wdsel));
        chk({tag, "/rd"},        32'(bus.rd),           32'(e.rd));
        chk({tag, "/RegWrite"},  32'(bus.RegWrite),     32'(e.regwrite));
        chk({tag, "/misalign"},  32'(bus.misalign_err), 32'(e.misalign_err));
        chk({tag, "/retire"},    bus.retire_cnt,        e.cnt);
        chk({tag, "/retire_n"},  32'(bus_n.retire_cnt), 32'(e.cnt_n));
    endtask

    localparam logic [31:0] WORD = 32'h8081_F2F3;

    initial begin
        bus.stall = 1'b1;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, DM_BYTE, 32'h1234_5679, WORD, 5'd7, 1'b1, WDSEL_MEM);

        // reset with busy inputs
        rst = 1'b1;
        step("rst0");
        step("rst1");
        rst = 1'b0;
        bus.stall = 1'b0;

        // load extraction table
        drive(1'b1, 1'b1, DM_BYTE,   32'h1000_0000, WORD, 5'd10, 1'b1, WDSEL_MEM);
        step("lb0");   chk("lb0_tbl", bus.dout, 32'hFFFF_FFF3);
        drive(1'b1, 1'b1, DM_BYTE_U, 32'h1000_0003, WORD, 5'd11, 1'b1, WDSEL_MEM);
        step("lbu3");  chk("lbu3_tbl", bus.dout, 32'h0000_0080);
        drive(1'b1, 1'b1, DM_HALF,   32'h1000_0002, WORD, 5'd12, 1'b1, WDSEL_MEM);
        step("lh2");   chk("lh2_tbl", bus.dout, 32'hFFFF_8081);
        drive(1'b1, 1'b1, DM_HALF_U, 32'h1000_0000, WORD, 5'd13, 1'b1, WDSEL_MEM);
        step("lhu0");  chk("lhu0_tbl", bus.dout, 32'h0000_F2F3);
        drive(1'b1, 1'b1, DM_WORD,   32'h1000_0000, WORD, 5'd14, 1'b1, WDSEL_MEM);
        step("lw0");   chk("lw0_tbl", bus.dout, 32'h8081_F2F3);
        drive(1'b1, 1'b1, 3'd6,      32'h1000_0000, WORD, 5'd14, 1'b1, WDSEL_MEM);
        step("undef_dm");

        // misaligned loads: one-cycle flag, no write, still retired
        drive(1'b1, 1'b1, DM_WORD, 32'h2000_0002, WORD, 5'd5, 1'b1, WDSEL_MEM);
        step("lw_mis");
        chk("lw_mis_flag", 32'(bus.misalign_err), 32'd1);
        chk("lw_mis_cnt", bus.retire_cnt, 32'd7);
        bus.stall = 1'b1;
        step("lw_mis_hold");
        bus.stall = 1'b0;
        drive(1'b1, 1'b1, DM_HALF, 32'h2000_0001, WORD, 5'd5, 1'b1, WDSEL_MEM);
        step("lh_mis");
        drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0, 5'd0, 1'b0, WDSEL_ALU);
        step("bubble");

        // x0 gating
        drive(1'b1, 1'b0, DM_WORD, 32'h0000_1234, WORD, 5'd0, 1'b1, WDSEL_ALU);
        step("x0");
        chk("x0_alu", bus.aluout, 32'h0000_1234);
        chk("x0_rw", 32'(bus.RegWrite), 32'd0);

        // stall holds A while inputs change
        drive(1'b1, 1'b0, DM_WORD, 32'h0000_000A, WORD, 5'd3, 1'b1, WDSEL_ALU);
        step("capA");
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom,
                  $urandom, 5'($urandom_range(1, 31)), 1'b1, 2'($urandom_range(0, 3)));
            step($sformatf("stall%0d", i));
            chk($sformatf("stall%0d_rd", i), 32'(bus.rd), 32'd3);
        end
        bus.flush = 1'b1;
        step("flush_stall");
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b0, DM_WORD, 32'h0000_00B0, WORD, 5'd9, 1'b1, WDSEL_PC);
        step("after_flush");
        bus.flush = 1'b1;
        step("flush_only");
        bus.flush = 1'b0;

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 16 && m.cnt_n != 4'hF; i++) begin
            drive(1'b1, 1'b0, DM_WORD, $urandom, WORD, 5'($urandom_range(0, 31)), 1'b1, WDSEL_IMM);
            step("fill");
        end
        chk("wrap_pre", 32'(bus_n.retire_cnt), 32'hF);
        drive(1'b1, 1'b0, DM_WORD, 32'h55, WORD, 5'd1, 1'b1, WDSEL_ALU);
        step("wrap");
        chk("wrap_zero", 32'(bus_n.retire_cnt), 32'h0);
        drive(1'b0, 1'b1, DM_WORD, 32'h56, WORD, 5'd1, 1'b1, WDSEL_ALU);
        step("wrap_bubble");
        chk("wrap_bubble_cnt", 32'(bus_n.retire_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
